rep3_serial_tx: RTL



---
 rtl/rep3_pkg.sv | 18 +
 rtl/rep3_phase_ctr.sv | 35 +++
 rtl/rep3_serial_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/rep3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rep3_pkg                                                             |
// | Shared constants and state encoding for the triple-repetition TX.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package rep3_pkg;

  localparam int REP_FACTOR = 3;
  localparam int PHASE_W    = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rep3_phase_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rep3_phase_ctr                                                       |
// | Mod-REP_FACTOR symbol phase counter with enable and sync clear.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rep3_phase_ctr
  import rep3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  localparam logic [PHASE_W-1:0] c_PHASE_MAX = PHASE_W'(REP_FACTOR - 1);

  logic [PHASE_W-1:0] r_phase;

  // Clear wins over enable so a reload on the final symbol starts at phase 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= (r_phase == c_PHASE_MAX) ? '0 : r_phase + PHASE_W'(1);
    end
  end

  assign phase = r_phase;
  assign wrap  = en && (r_phase == c_PHASE_MAX);

endmodule
`default_nettype wire

// File: rtl/rep3_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rep3_serial_tx                                                       |
// | Word-to-serial encoder sending each bit MSB-first as three symbols.  |
// | Optional even-parity stage enabled by macro REP3_PARITY_EN.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rep3_serial_tx
  import rep3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_last,
  output logic              busy
);

`ifdef REP3_PARITY_EN
  localparam int c_FRAME_BITS = DATA_W + 1;
`else
  localparam int c_FRAME_BITS = DATA_W;
`endif
  localparam int c_CNT_W = (c_FRAME_BITS > 1) ? $clog2(c_FRAME_BITS) : 1;
  localparam logic [PHASE_W-1:0] c_PHASE_MAX = PHASE_W'(REP_FACTOR - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_FRAME_BITS-1:0] r_shift;
  logic [c_FRAME_BITS-1:0] w_load_word;
  logic [c_CNT_W-1:0]      r_bit_cnt;
  logic [PHASE_W-1:0]      w_phase;
  logic                    w_wrap;
  logic                    w_xfer;
  logic                    w_accept;
  logic                    w_frame_end;

  // Parity rides as an extra low-order bit so it shifts out after the data.
`ifdef REP3_PARITY_EN
  assign w_load_word = {in_data, ^in_data};
`else
  assign w_load_word = in_data;
`endif

  assign w_xfer      = (r_state == SEND) && tx_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_frame_end = (r_bit_cnt == '0) && (w_phase == c_PHASE_MAX);

  rep3_phase_ctr u_phase_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_xfer),
    .clr   (w_accept),
    .phase (w_phase),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = SEND;
      SEND: if (w_xfer && w_frame_end && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_bit   = 1'b0;
    tx_last  = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = r_shift[c_FRAME_BITS-1];
        tx_last  = w_frame_end;
        in_ready = w_frame_end && tx_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= w_load_word;
      r_bit_cnt <= c_CNT_W'(c_FRAME_BITS - 1);
    end else if (w_wrap) begin
      r_shift <= r_shift << 1;
      if (r_bit_cnt != '0) begin
        r_bit_cnt <= r_bit_cnt - c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
